// File: rtl/pwm_cmd_pkg.sv
// Shared constants for the PWM command receiver: sync byte, parser states,
// channel indices and the reset/failsafe duty counts.
package pwm_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [2:0] P_HUNT = 3'd0;
    localparam logic [2:0] P_CHAN = 3'd1;
    localparam logic [2:0] P_HI   = 3'd2;
    localparam logic [2:0] P_LO   = 3'd3;
    localparam logic [2:0] P_CSUM = 3'd4;

    localparam int CH_SERVO0 = 0;
    localparam int CH_ESC    = 1;
    localparam int CH_SERVO1 = 2;

    localparam int DUTY_CENTER = 18000;  // 1500 us at 12 MHz
    localparam int DUTY_DISARM = 12000;  // 1000 us at 12 MHz

    // Servos park at centre; the ESC parks at its disarm pulse.
    function automatic int reset_duty(input int ch);
        if (ch == CH_SERVO0 || ch == CH_SERVO1)
            return DUTY_CENTER;
        else if (ch == CH_ESC)
            return DUTY_DISARM;
        else
            return DUTY_CENTER;
    endfunction

endpackage

// File: rtl/pwm_cmd_receiver_uart_rx.sv
// 8N1 UART receiver: two-flop rxd synchroniser, mid-bit sampling, one strobe
// per good byte and a strobe for a stop bit sampled low.
module uart_rx_8n1 #(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);
    localparam int BIT_TICKS = CLK_HZ / BAUD;
    localparam int HALF      = BIT_TICKS / 2;
    localparam int CW        = $clog2(BIT_TICKS + 1);

    localparam logic [1:0] U_IDLE  = 2'd0;
    localparam logic [1:0] U_START = 2'd1;
    localparam logic [1:0] U_DATA  = 2'd2;
    localparam logic [1:0] U_STOP  = 2'd3;

    logic          rx_meta, rx_sync, rx_prev;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign rx_byte = shreg;

    // NOTE: all state here is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours, matching hardware.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            state    <= U_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= rxd;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (state)
                U_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= U_START;
                        cnt   <= '0;
                    end
                end
                U_START: begin
                    // A glitch that is gone by mid start bit is dropped silently.
                    if (cnt == CW'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? U_IDLE : U_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                U_DATA: begin
                    if (cnt == CW'(BIT_TICKS - 1)) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= U_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == CW'(BIT_TICKS - 1)) begin
                        cnt      <= '0;
                        state    <= U_IDLE;
                        rx_valid <= rx_sync;
                        rx_ferr  <= !rx_sync;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_cmd_receiver.sv
// PWM command receiver top: frame parser, inter-byte gap timer, clamp/scale and
// duty registers. Define PWM_CMD_FAILSAFE_EN to add the no-command watchdog.
module pwm_cmd_receiver
    import pwm_cmd_pkg::*;
#(
    parameter int CLK_HZ    = 12_000_000,
    parameter int BAUD      = 115_200,
    parameter int NUM_CH    = 3,
    parameter int DW        = 19,
    parameter int PW_MIN_US = 1000,
    parameter int PW_MAX_US = 2000,
    parameter int GAP_US    = 1000
`ifdef PWM_CMD_FAILSAFE_EN
    ,
    parameter int FS_TIMEOUT_MS = 100
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [NUM_CH*DW-1:0] duty_flat,
    output logic [NUM_CH-1:0]    upd,
    output logic                 frame_err,
    output logic                 failsafe
);
    localparam int TICKS_PER_US = CLK_HZ / 1_000_000;
    localparam int GAP_TICKS    = GAP_US * TICKS_PER_US;
    localparam int GW           = $clog2(GAP_TICKS + 1);

    logic [7:0]    rx_byte;
    logic          rx_valid, rx_ferr;
    logic [2:0]    pstate;
    logic [7:0]    ch_r, hi_r, lo_r;
    logic [GW-1:0] gap_cnt;
    logic [15:0]   pw_raw, pw_clamped;
    logic [DW-1:0] ticks;
    logic          cs_ok, ch_ok, gap_timeout, accept, fs_fire;
    logic [DW-1:0] duty [NUM_CH];

    uart_rx_8n1 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    assign pw_raw      = {hi_r, lo_r};
    assign pw_clamped  = (pw_raw < 16'(PW_MIN_US)) ? 16'(PW_MIN_US) :
                         (pw_raw > 16'(PW_MAX_US)) ? 16'(PW_MAX_US) : pw_raw;
    // x12 as shift-and-add keeps the scaler multiplier-free.
    assign ticks       = (DW'(pw_clamped) << 3) + (DW'(pw_clamped) << 2);
    assign cs_ok       = (rx_byte == (ch_r ^ hi_r ^ lo_r));
    assign ch_ok       = ({24'd0, ch_r} < 32'(NUM_CH));
    assign gap_timeout = (pstate != P_HUNT) && (gap_cnt == GW'(GAP_TICKS));
    assign accept      = rx_valid && !gap_timeout && (pstate == P_CSUM) && cs_ok && ch_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pstate    <= P_HUNT;
            ch_r      <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            gap_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (rx_valid || pstate == P_HUNT)
                gap_cnt <= '0;
            else if (gap_cnt != GW'(GAP_TICKS))
                gap_cnt <= gap_cnt + 1'b1;

            if (rx_ferr || gap_timeout) begin
                frame_err <= 1'b1;
                pstate    <= P_HUNT;
            end else if (rx_valid) begin
                case (pstate)
                    P_HUNT: if (rx_byte == SYNC_BYTE) pstate <= P_CHAN;
                    P_CHAN: begin ch_r <= rx_byte; pstate <= P_HI; end
                    P_HI:   begin hi_r <= rx_byte; pstate <= P_LO; end
                    P_LO:   begin lo_r <= rx_byte; pstate <= P_CSUM; end
                    default: begin
                        frame_err <= !(cs_ok && ch_ok);
                        pstate    <= P_HUNT;
                    end
                endcase
            end
        end
    end

`ifdef PWM_CMD_FAILSAFE_EN
    localparam int MS_TICKS = CLK_HZ / 1000;
    localparam int MW       = $clog2(MS_TICKS + 1);
    localparam int FW       = $clog2(FS_TIMEOUT_MS + 1);

    logic [MW-1:0] ms_pre;
    logic [FW-1:0] ms_cnt;

    assign fs_fire = !failsafe && !accept && (ms_pre == MW'(MS_TICKS - 1)) &&
                     (ms_cnt == FW'(FS_TIMEOUT_MS - 1));

    // Watchdog freezes once tripped so the all-channel upd fires only once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ms_pre   <= '0;
            ms_cnt   <= '0;
            failsafe <= 1'b0;
        end else if (accept) begin
            ms_pre   <= '0;
            ms_cnt   <= '0;
            failsafe <= 1'b0;
        end else if (!failsafe) begin
            if (ms_pre == MW'(MS_TICKS - 1)) begin
                ms_pre <= '0;
                if (fs_fire) begin
                    ms_cnt   <= '0;
                    failsafe <= 1'b1;
                end else begin
                    ms_cnt <= ms_cnt + 1'b1;
                end
            end else begin
                ms_pre <= ms_pre + 1'b1;
            end
        end
    end
`else
    assign fs_fire  = 1'b0;
    assign failsafe = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd <= '0;
            for (int i = 0; i < NUM_CH; i++)
                duty[i] <= DW'(reset_duty(i));
        end else begin
            upd <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept && ch_r == 8'(i)) begin
                    duty[i] <= ticks;
                    upd[i]  <= 1'b1;
                end else if (fs_fire) begin
                    duty[i] <= DW'(reset_duty(i));
                    upd[i]  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        duty_flat = '0;
        for (int i = 0; i < NUM_CH; i++)
            duty_flat[i*DW +: DW] = duty[i];
    end

endmodule

// File: tb/tb_pwm_cmd_receiver.sv
// Self-checking bench for pwm_cmd_receiver: directed frames, error cases and
// random frames checked against a frame-level model of the duty registers.
module tb_pwm_cmd_receiver;
    localparam int CLK_HZ  = 12_000_000;
    localparam int BAUD    = 1_000_000;   // short bit time keeps the run brief
    localparam int BIT     = CLK_HZ / BAUD;
    localparam int GAP_US  = 200;
    localparam int GAP_CYC = GAP_US * (CLK_HZ / 1_000_000);
    localparam int FS_MS   = 2;
    localparam int DW      = 19;
    localparam int NCH     = 3;

    logic              clk = 1'b0;
    logic              rst_n, rxd;
    logic [NCH*DW-1:0] duty_flat;
    logic [NCH-1:0]    upd;
    logic              frame_err, failsafe;

    always #5 clk = ~clk;

    pwm_cmd_receiver #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_CH(NCH), .DW(DW),
        .PW_MIN_US(1000), .PW_MAX_US(2000), .GAP_US(GAP_US)
`ifdef PWM_CMD_FAILSAFE_EN
        , .FS_TIMEOUT_MS(FS_MS)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .duty_flat (duty_flat),
        .upd       (upd),
        .frame_err (frame_err),
        .failsafe  (failsafe)
    );

    int              cmp_cnt = 0;
    int              fail_cnt = 0;
    int              upd_cnt, err_cnt;
    logic [NCH-1:0]  upd_last;
    logic [NCH*DW-1:0] upd_flat;
    int              exp_duty [NCH];
    logic            exp_fs;

    always @(negedge clk) begin
        if (upd != '0) begin
            upd_cnt  = upd_cnt + 1;
            upd_last = upd;
            upd_flat = duty_flat;
        end
        if (frame_err)
            err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        upd_cnt  = 0;
        err_cnt  = 0;
        upd_last = '0;
        upd_flat = '0;
    endtask

    task automatic model_reset();
        exp_duty[0] = 18000;
        exp_duty[1] = 12000;
        exp_duty[2] = 18000;
        exp_fs      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(posedge clk);
        end
        rxd = stop_bit;
        repeat (BIT) @(posedge clk);
        rxd = 1'b1;
        repeat (BIT) @(posedge clk);
    endtask

    task automatic check_state(input logic [NCH-1:0] eu, input logic ee, input string tag);
        @(negedge clk);
        check({tag, "/upd_pulses"}, upd_cnt, (eu != '0) ? 1 : 0);
        check({tag, "/upd_mask"}, 32'(upd_last), 32'(eu));
        check({tag, "/frame_err"}, err_cnt, ee ? 1 : 0);
        check({tag, "/failsafe"}, 32'(failsafe), 32'(exp_fs));
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("%s/duty%0d", tag, i), 32'(duty_flat[i*DW +: DW]), exp_duty[i]);
            if (eu[i])
                check($sformatf("%s/duty%0d_at_upd", tag, i), 32'(upd_flat[i*DW +: DW]), exp_duty[i]);
        end
    endtask

    // Sends a full frame and checks the outcome the frame rules predict.
    task automatic run_frame(input logic [7:0] ch, hi, lo, cs, input string tag);
        int             pw;
        logic [NCH-1:0] eu;
        logic           ee;
        send_byte(8'hA5, 1'b1);
        send_byte(ch, 1'b1);
        send_byte(hi, 1'b1);
        send_byte(lo, 1'b1);
        send_byte(cs, 1'b1);
        repeat (4) @(posedge clk);
        eu = '0;
        ee = 1'b0;
        if (cs == (ch ^ hi ^ lo) && int'(ch) < NCH) begin
            pw = int'({hi, lo});
            if (pw < 1000) pw = 1000;
            if (pw > 2000) pw = 2000;
            exp_duty[int'(ch)] = pw * 12;
            eu[int'(ch)]       = 1'b1;
            exp_fs             = 1'b0;
        end else begin
            ee = 1'b1;
        end
        check_state(eu, ee, tag);
    endtask

    initial begin
        logic [7:0] rch, rhi, rlo, rcs;
        logic [15:0] rpw;
        rxd   = 1'b1;
        rst_n = 1'b0;
        clear_mon();
        model_reset();
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        check_state('0, 1'b0, "reset");

        clear_mon(); run_frame(8'h00, 8'h05, 8'hDC, 8'hD9, "ch0_1500us");
        clear_mon(); run_frame(8'h01, 8'h0F, 8'hA0, 8'hAE, "clamp_high");
        clear_mon(); run_frame(8'h01, 8'h01, 8'hF4, 8'hF4, "clamp_low");
        clear_mon(); run_frame(8'h02, 8'h07, 8'hD0, 8'h00, "bad_cs");
        clear_mon(); run_frame(8'h02, 8'h07, 8'hD0, 8'hD5, "after_bad_cs");
        clear_mon(); run_frame(8'h00, 8'hA5, 8'hA5, 8'h00, "sync_as_data");
        clear_mon(); run_frame(8'h03, 8'h05, 8'hDC, 8'hDA, "bad_chan");

        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h07, 1'b0);
        send_byte(8'hD0, 1'b1);
        send_byte(8'hD6, 1'b1);
        repeat (4) @(posedge clk);
        check_state('0, 1'b1, "stop_err");
        clear_mon(); run_frame(8'h01, 8'h05, 8'hDC, 8'hD8, "after_stop_err");

        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (2 * GAP_CYC) @(posedge clk);
        check_state('0, 1'b1, "gap_timeout");
        clear_mon(); run_frame(8'h02, 8'h03, 8'hE8, 8'hE9, "after_gap");

        clear_mon();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        run_frame(8'h02, 8'h06, 8'h40, 8'h44, "junk_then_frame");

        for (int n = 0; n < 10; n++) begin
            rch = 8'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       rpw = 16'd999;
                1:       rpw = 16'd1000;
                2:       rpw = 16'd2000;
                3:       rpw = 16'd2001;
                default: rpw = 16'($urandom_range(0, 65535));
            endcase
            rhi = rpw[15:8];
            rlo = rpw[7:0];
            rcs = rch ^ rhi ^ rlo;
            if ($urandom_range(0, 3) == 0)
                rcs = rcs ^ 8'($urandom_range(1, 255));
            clear_mon();
            run_frame(rch, rhi, rlo, rcs, $sformatf("rand%0d", n));
        end

        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(posedge clk);
        check_state('0, 1'b0, "reset_mid_frame");
        clear_mon(); run_frame(8'h00, 8'h06, 8'h40, 8'h46, "after_reset");

        clear_mon(); run_frame(8'h01, 8'h05, 8'hDC, 8'hD8, "esc_1500us");
        clear_mon();
        repeat ((FS_MS + 1) * (CLK_HZ / 1000)) @(posedge clk);
`ifdef PWM_CMD_FAILSAFE_EN
        model_reset();
        exp_fs = 1'b1;
        check_state('1, 1'b0, "failsafe_trip");
`else
        check_state('0, 1'b0, "idle_hold");
`endif
        clear_mon(); run_frame(8'h00, 8'h05, 8'hDC, 8'hD9, "after_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
